// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } frame_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BAD_LEN = 3'd1,
        ERR_BAD_CHK = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } frame_err_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/frame_payload_buf.sv
// Payload staging buffer: one synchronous write port, one combinational read port, no reset.
module frame_payload_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store incoming payload bytes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: hunts SYNC, LEN, payload, CHK; buffers payload until the XOR checksum
// passes, then streams it out over valid/ready. Errors pulse frame_err with a held code.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC,
    parameter int unsigned TIMEOUT_CYCLES = 86800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
    localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    frame_state_t     state_q, state_d;
    frame_err_t       code_q, code_d;
    logic [7:0]       len_q;
    logic [7:0]       len_m1;
    logic [7:0]       chk_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [TW-1:0]    tmo_q;
    logic             ok_d, err_d, buf_we;
    logic             hs, in_frame, tmo_hit, rd_is_last;
    logic [7:0]       rd_data;

    assign len_m1     = len_q - 8'd1;
    assign hs         = m_valid && m_ready;
    assign in_frame   = state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    assign tmo_hit    = in_frame && !rx_valid && (tmo_q == TMO_LAST);
    assign rd_is_last = (8'(rd_idx_q) == len_m1);

    frame_payload_buf #(
        .DEPTH(MAX_LEN),
        .AW   (AW)
    ) u_buf (
        .clk  (clk),
        .we   (buf_we),
        .waddr(idx_q[AW-1:0]),
        .wdata(rx_data),
        .raddr(rd_idx_q[AW-1:0]),
        .rdata(rd_data)
    );

    assign m_data   = (state_q == ST_DRAIN) ? rd_data : '0;
    assign m_last   = (state_q == ST_DRAIN) && rd_is_last;
    assign err_code = code_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle status decisions; timeout overrides the frame states.
    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        buf_we  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (32'(rx_data) > MAX_LEN)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_LEN;
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    if (8'(idx_q) == len_m1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        ok_d    = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_CHK;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                if (hs && rd_is_last) begin
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = ST_HUNT;
        end
    end

    // Registered status outputs, length/checksum/index datapath and inter-byte timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            code_q    <= ERR_NONE;
            m_valid   <= 1'b0;
            len_q     <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            tmo_q     <= '0;
        end else begin
            frame_ok  <= ok_d;
            frame_err <= err_d;
            code_q    <= code_d;
            m_valid   <= (state_d == ST_DRAIN);

            if (rx_valid || !in_frame) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            if ((state_q == ST_LEN) && rx_valid) begin
                len_q <= rx_data;
                chk_q <= rx_data;
                idx_q <= '0;
            end

            if (buf_we) begin
                chk_q <= chk_q ^ rx_data;
                idx_q <= idx_q + IDX_W'(1);
            end

            if (ok_d) begin
                rd_idx_q <= '0;
            end else if (hs) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table-driven frames plus multi-cycle corner cases,
// payload and error codes checked through scoreboard queues.
module tb_uart_frame_parser;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    uart_frame_parser #(
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } out_t;

    typedef struct {
        int           n;
        logic [159:0] b;
        bit           ok;
        int           p0;
        int           plen;
        int           err;
    } vec_t;

    out_t exp_q[$];
    int   err_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ok_cnt = 0;
    int   rdy_mode = 0;
    int   rdy_phase = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] vbyte(input logic [159:0] b, input int n, input int i);
        return b[8*(n-1-i) +: 8];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_out(input logic [7:0] d, input logic l);
        out_t o;
        o.d = d;
        o.l = l;
        exp_q.push_back(o);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready   = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase = rdy_phase + 1;
            end
            default: m_ready = 1'b0;
        endcase
    end

    // Output monitor: every presented byte must match the scoreboard head; errors match the code queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_m_valid", int'(m_data), 0);
                end else begin
                    chk("m_data", int'(m_data), int'(exp_q[0].d));
                    chk("m_last", int'(m_last), int'(exp_q[0].l));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) fail("unexpected_frame_err", int'(err_code), 0);
                else chk("err_code", int'(err_code), err_q.pop_front());
            end
            if (frame_ok) begin
                ok_cnt++;
                chk("m_valid_with_ok", int'(m_valid), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ok_before;
        logic [159:0] b;

        vecs[0] = '{n: 8,  b: 160'h007FA50311223303, ok: 1, p0: 4, plen: 3,  err: 0};
        vecs[1] = '{n: 6,  b: 160'hA50311223304,     ok: 0, p0: 0, plen: 0,  err: 2};
        vecs[2] = '{n: 5,  b: 160'hA502ABCD64,       ok: 1, p0: 2, plen: 2,  err: 0};
        vecs[3] = '{n: 2,  b: 160'hA500,             ok: 0, p0: 0, plen: 0,  err: 1};
        vecs[4] = '{n: 2,  b: 160'hA511,             ok: 0, p0: 0, plen: 0,  err: 1};
        vecs[5] = '{n: 4,  b: 160'hA501A5A4,         ok: 1, p0: 2, plen: 1,  err: 0};
        vecs[6] = '{n: 2,  b: 160'hA5A5,             ok: 0, p0: 0, plen: 0,  err: 1};
        vecs[7] = '{n: 19, b: 160'hA510000102030405060708090A0B0C0D0E0F10, ok: 1, p0: 2, plen: 16, err: 0};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_frame_ok", int'(frame_ok), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_err_code", int'(err_code), 0);
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < 8; v++) begin
            ok_before = ok_cnt;
            b = vecs[v].b;
            if (vecs[v].ok) begin
                for (int i = 0; i < vecs[v].plen; i++) begin
                    push_out(vbyte(b, vecs[v].n, vecs[v].p0 + i), (i == vecs[v].plen - 1));
                end
            end
            if (vecs[v].err != 0) err_q.push_back(vecs[v].err);
            for (int i = 0; i < vecs[v].n; i++) send_byte(vbyte(b, vecs[v].n, i));
            wait_drain();
            idle(3);
            chk("vec_ok_count", ok_cnt - ok_before, int'(vecs[v].ok));
            chk("vec_err_pending", err_q.size(), 0);
            if (vecs[v].err != 0) chk("vec_err_held", int'(err_code), vecs[v].err);
        end

        // Inter-byte silence of a full timeout period aborts the frame.
        err_q.push_back(3);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAB);
        idle(TMO + 3);
        chk("timeout_err_pending", err_q.size(), 0);
        chk("timeout_code", int'(err_code), 3);

        // Byte landing exactly on the expiry cycle is accepted.
        ok_before = ok_cnt;
        push_out(8'hAB, 1'b0);
        push_out(8'hCD, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAB);
        idle(TMO - 1);
        send_byte(8'hCD);
        send_byte(8'h64);
        wait_drain();
        idle(3);
        chk("expiry_ok", ok_cnt - ok_before, 1);
        chk("expiry_no_err", err_q.size(), 0);

        // Back-pressured drain with ready toggling 1,0,0,1.
        ok_before = ok_cnt;
        rdy_mode  = 1;
        push_out(8'hDE, 1'b0);
        push_out(8'hAD, 1'b0);
        push_out(8'hBE, 1'b0);
        push_out(8'hEF, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h26);
        wait_drain();
        rdy_mode = 0;
        idle(3);
        chk("toggle_ok", ok_cnt - ok_before, 1);

        // Strobes during a stalled drain are overruns; the payload is still delivered.
        ok_before = ok_cnt;
        rdy_mode  = 2;
        idle(2);
        push_out(8'hAB, 1'b0);
        push_out(8'hCD, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h64);
        err_q.push_back(4);
        err_q.push_back(4);
        send_byte(8'h55);
        send_byte(8'hA5);
        idle(2);
        chk("overrun_err_pending", err_q.size(), 0);
        chk("overrun_code", int'(err_code), 4);
        chk("overrun_still_valid", int'(m_valid), 1);
        rdy_mode = 0;
        wait_drain();
        idle(3);
        chk("overrun_ok", ok_cnt - ok_before, 1);

        // Reset mid-payload clears outputs asynchronously; the next frame parses normally.
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_err_code", int'(err_code), 0);
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_m_data", int'(m_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(TMO + 5);
        ok_before = ok_cnt;
        push_out(8'h11, 1'b0);
        push_out(8'h22, 1'b0);
        push_out(8'h33, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        wait_drain();
        idle(3);
        chk("postrst_ok", ok_cnt - ok_before, 1);
        chk("postrst_no_err", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
